// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage: register file, load-use hazard stall, decode output register
// Optional same-cycle writeback-to-read bypass is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NDBG     = 4,
   parameter int DBG_BASE = 8,
   localparam int AW      = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_valid,
   input  logic [XLEN-1:0]      if_pc,
   input  logic [31:0]          if_inst,
   output logic                 id_ready,
   input  logic                 ex_ready,
   input  logic                 ex_mem_read,
   input  logic [AW-1:0]        ex_rt,
   input  logic                 wb_we,
   input  logic [AW-1:0]        wb_addr,
   input  logic [XLEN-1:0]      wb_data,
   output logic                 id_valid,
   output logic [XLEN-1:0]      id_pc,
   output logic [XLEN-1:0]      id_rd1,
   output logic [XLEN-1:0]      id_rd2,
   output logic [XLEN-1:0]      id_imm,
   output logic [5:0]           id_op,
   output logic [4:0]           id_rs,
   output logic [4:0]           id_rt,
   output logic [4:0]           id_rd,
   output logic [5:0]           id_funct,
   output logic [NDBG*XLEN-1:0] dbg
);

   logic [XLEN-1:0] rf [NREG];

   logic [5:0]      op;
   logic [5:0]      funct;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic            hazard;
   logic            load;
   logic            zext;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic [XLEN-1:0] imm;

   assign op    = if_inst[31:26];
   assign rs    = if_inst[25:21];
   assign rt    = if_inst[20:16];
   assign rd    = if_inst[15:11];
   assign funct = if_inst[5:0];

   // Register 0 is hard-wired to zero; the bypass never applies to it either.
   function automatic logic [XLEN-1:0] rf_read(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      v = (a == '0) ? '0 : rf[a];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_we && (wb_addr == a) && (a != '0))
         v = wb_data;
`endif
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= '0;
      end else if (wb_we && (wb_addr != '0)) begin
         rf[wb_addr] <= wb_data;
      end
   end

   // Load-use: the load in EX has not produced its data yet, so hold the consumer in fetch.
   always_comb begin
      hazard = 1'b0;
      if (if_valid && ex_mem_read && (ex_rt != '0))
         hazard = (32'(ex_rt) == 32'(rs)) || (32'(ex_rt) == 32'(rt));
   end

   assign id_ready = (!id_valid || ex_ready) && !hazard;
   assign load     = if_valid && id_ready;

   always_comb begin
      zext = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
      imm  = zext ? XLEN'(if_inst[15:0]) : XLEN'($signed(if_inst[15:0]));
      rd1  = rf_read(AW'(rs));
      rd2  = rf_read(AW'(rt));
   end

   always_comb begin
      dbg = '0;
      for (int k = 0; k < NDBG; k++)
         dbg[k*XLEN +: XLEN] = rf_read(AW'(DBG_BASE + k));
   end

   // Fields are only refreshed on a load; a bubble clears just the valid flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_rd1   <= '0;
         id_rd2   <= '0;
         id_imm   <= '0;
         id_op    <= '0;
         id_rs    <= '0;
         id_rt    <= '0;
         id_rd    <= '0;
         id_funct <= '0;
      end else if (load) begin
         id_valid <= 1'b1;
         id_pc    <= if_pc;
         id_rd1   <= rd1;
         id_rd2   <= rd2;
         id_imm   <= imm;
         id_op    <= op;
         id_rs    <= rs;
         id_rt    <= rt;
         id_rd    <= rd;
         id_funct <= funct;
      end else if (ex_ready) begin
         id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage with a behavioural reference model
module tb_decode_stage;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NDBG = 4;
   localparam int DBG_BASE = 8;
   localparam int AW = 5;

   logic                 clk;
   logic                 rst;
   logic                 if_valid;
   logic [XLEN-1:0]      if_pc;
   logic [31:0]          if_inst;
   logic                 id_ready;
   logic                 ex_ready;
   logic                 ex_mem_read;
   logic [AW-1:0]        ex_rt;
   logic                 wb_we;
   logic [AW-1:0]        wb_addr;
   logic [XLEN-1:0]      wb_data;
   logic                 id_valid;
   logic [XLEN-1:0]      id_pc, id_rd1, id_rd2, id_imm;
   logic [5:0]           id_op, id_funct;
   logic [4:0]           id_rs, id_rt, id_rd;
   logic [NDBG*XLEN-1:0] dbg;

   decode_stage #(.XLEN(XLEN), .NREG(NREG), .NDBG(NDBG), .DBG_BASE(DBG_BASE)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .id_ready(id_ready), .ex_ready(ex_ready), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .id_valid(id_valid),
      .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_op(id_op),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .dbg(dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mrf [NREG];
   logic        exp_valid;
   logic [31:0] exp_pc, exp_rd1, exp_rd2, exp_imm, exp_inst;

   function automatic logic [31:0] mread(input int idx);
      if (idx == 0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
      if (wb_we && (int'(wb_addr) == idx)) return wb_data;
`endif
      return mrf[idx];
   endfunction

   function automatic logic m_hazard();
      return if_valid && ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == if_inst[25:21]) || (ex_rt == if_inst[20:16]));
   endfunction

   function automatic logic m_ready();
      return (!exp_valid || ex_ready) && !m_hazard();
   endfunction

   function automatic logic [31:0] m_imm(input logic [31:0] inst);
      int v;
      v = int'(inst[15:0]);
      if (inst[31:26] == 6'h0C || inst[31:26] == 6'h0D || inst[31:26] == 6'h0E) return v;
      if (v >= 32768) v = v - 65536;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) mrf[i] = 32'h0;
      exp_valid = 0; exp_pc = 0; exp_rd1 = 0; exp_rd2 = 0; exp_imm = 0; exp_inst = 0;
   endtask

   // One clock: predicts the edge from pre-edge inputs, then waits past it.
   task automatic tick();
      logic ld;
      logic [31:0] n_rd1, n_rd2, n_imm;
      ld    = if_valid && m_ready();
      n_rd1 = mread(int'(if_inst[25:21]));
      n_rd2 = mread(int'(if_inst[20:16]));
      n_imm = m_imm(if_inst);
      @(posedge clk);
      if (ld) begin
         exp_valid = 1; exp_pc = if_pc; exp_inst = if_inst;
         exp_rd1 = n_rd1; exp_rd2 = n_rd2; exp_imm = n_imm;
      end else if (ex_ready) begin
         exp_valid = 0;
      end
      if (wb_we && wb_addr != 0) mrf[wb_addr] = wb_data;
      #1;
   endtask

   task automatic idle();
      if_valid = 0; if_pc = 0; if_inst = 0; ex_ready = 1; ex_mem_read = 0;
      ex_rt = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
   endtask

   task automatic test_reset();
      rst = 0; idle(); model_reset();
      #3;
      n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", id_valid); end
      n_cmp++; if (id_pc !== 32'h0 || id_imm !== 32'h0) begin n_err++; $display("FAIL reset_fields got pc %h imm %h exp 0", id_pc, id_imm); end
      n_cmp++; if (dbg !== '0) begin n_err++; $display("FAIL reset_dbg got %h exp 0", dbg); end
      n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", id_ready); end
      #9 rst = 1;
   endtask

   task automatic test_write_dbg();
      idle(); wb_we = 1; wb_addr = 8; wb_data = 32'h1234;
      tick();
      wb_we = 0; #1;
      n_cmp++; if (dbg[31:0] !== 32'h1234) begin n_err++; $display("FAIL dbg_lane0 got %h exp 00001234", dbg[31:0]); end
      n_cmp++; if (dbg[127:32] !== '0) begin n_err++; $display("FAIL dbg_lanes123 got %h exp 0", dbg[127:32]); end
   endtask

   task automatic test_reg0();
      idle(); wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
      tick();
      wb_we = 0; if_valid = 1; if_pc = 32'h40; if_inst = 32'h00000020;
      tick();
      n_cmp++; if (id_valid !== 1'b1 || id_rd1 !== 32'h0) begin n_err++; $display("FAIL reg0_read got v=%b rd1=%h exp v=1 rd1=0", id_valid, id_rd1); end
   endtask

   task automatic test_imm();
      idle(); if_valid = 1; if_pc = 32'h80; if_inst = 32'h2008FFFF;
      tick();
      n_cmp++; if (id_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL imm_addi got %h exp ffffffff", id_imm); end
      n_cmp++; if (id_op !== 6'h08 || id_rt !== 5'd8) begin n_err++; $display("FAIL imm_addi_fields got op %h rt %0d exp 08/8", id_op, id_rt); end
      if_inst = 32'h3508FFFF;
      tick();
      n_cmp++; if (id_imm !== 32'h0000FFFF) begin n_err++; $display("FAIL imm_ori got %h exp 0000ffff", id_imm); end
      for (int i = 0; i < 12; i++) begin
         if_inst = {6'(6'h0B + (i % 5)), 10'($urandom), 16'($urandom)};
         tick();
         n_cmp++; if (id_imm !== exp_imm) begin n_err++; $display("FAIL imm_rand inst %h got %h exp %h", exp_inst, id_imm, exp_imm); end
      end
   endtask

   task automatic test_load_use();
      idle(); tick();
      if_valid = 1; if_pc = 32'h100; if_inst = 32'h8D230004; ex_mem_read = 1; ex_rt = 9;
      #1;
      n_cmp++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL lu_ready_stall got %b exp 0", id_ready); end
      tick();
      n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL lu_valid_stall got %b exp 0", id_valid); end
      ex_mem_read = 0; #1;
      n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL lu_ready_release got %b exp 1", id_ready); end
      tick();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_rs !== 5'd9) begin n_err++; $display("FAIL lu_accept got v=%b pc=%h rs=%0d exp 1/100/9", id_valid, id_pc, id_rs); end
   endtask

   task automatic test_backpressure();
      idle(); if_valid = 1; if_pc = 32'h200; if_inst = 32'h01000820;
      tick();
      ex_ready = 0; if_pc = 32'h204; if_inst = 32'h3508FFFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc %0d got %b exp 0", i, id_ready); end
         tick();
         n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_rd1 !== 32'h1234) begin n_err++; $display("FAIL bp_hold cyc %0d got v=%b pc=%h rd1=%h exp 1/200/1234", i, id_valid, id_pc, id_rd1); end
      end
      ex_ready = 1; #1;
      n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %b exp 1", id_ready); end
      tick();
      n_cmp++; if (id_pc !== 32'h204 || id_imm !== 32'h0000FFFF) begin n_err++; $display("FAIL bp_next got pc=%h imm=%h exp 204/0000ffff", id_pc, id_imm); end
   endtask

   task automatic test_bypass();
      logic [31:0] want;
`ifdef DECODE_WB_BYPASS_EN
      want = 32'hABCD;
`else
      want = 32'h0;
`endif
      idle(); if_valid = 1; if_pc = 32'h300; if_inst = 32'h01400020;
      wb_we = 1; wb_addr = 10; wb_data = 32'hABCD;
      tick();
      n_cmp++; if (id_rd1 !== want) begin n_err++; $display("FAIL bypass_same_cycle got %h exp %h", id_rd1, want); end
      wb_we = 0; if_pc = 32'h304;
      tick();
      n_cmp++; if (id_rd1 !== 32'hABCD) begin n_err++; $display("FAIL bypass_next_cycle got %h exp 0000abcd", id_rd1); end
   endtask

   task automatic test_random();
      logic [5:0] ops [8];
      ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h3F};
      for (int c = 0; c < 400; c++) begin
         if_valid    = ($urandom_range(0, 3) != 0);
         if_pc       = $urandom;
         if_inst     = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 16'($urandom)};
         ex_ready    = ($urandom_range(0, 3) != 0);
         ex_mem_read = ($urandom_range(0, 2) == 0);
         ex_rt       = 5'($urandom_range(0, 15));
         wb_we       = $urandom_range(0, 1) == 1;
         wb_addr     = 5'($urandom_range(0, 15));
         wb_data     = $urandom;
         #1;
         n_cmp++; if (id_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, id_ready, m_ready()); end
         for (int k = 0; k < NDBG; k++) begin
            n_cmp++; if (dbg[k*XLEN +: XLEN] !== mread(DBG_BASE + k)) begin n_err++; $display("FAIL rnd_dbg cyc %0d lane %0d got %h exp %h", c, k, dbg[k*XLEN +: XLEN], mread(DBG_BASE + k)); end
         end
         tick();
         n_cmp++; if (id_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, id_valid, exp_valid); end
         if (exp_valid) begin
            n_cmp++;
            if (id_pc !== exp_pc || id_rd1 !== exp_rd1 || id_rd2 !== exp_rd2 || id_imm !== exp_imm) begin
               n_err++; $display("FAIL rnd_data cyc %0d got pc=%h a=%h b=%h imm=%h exp %h/%h/%h/%h", c, id_pc, id_rd1, id_rd2, id_imm, exp_pc, exp_rd1, exp_rd2, exp_imm);
            end
            n_cmp++;
            if ({id_op, id_rs, id_rt, id_rd, id_funct} !== {exp_inst[31:11], exp_inst[5:0]}) begin
               n_err++; $display("FAIL rnd_fields cyc %0d got %h exp inst %h", c, {id_op, id_rs, id_rt, id_rd, id_funct}, exp_inst);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      idle(); if_valid = 1; if_pc = 32'h500; if_inst = 32'h20080001;
      tick();
      ex_ready = 0; if_valid = 0;
      n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid got %b exp 1", id_valid); end
      #2 rst = 0;
      #1;
      n_cmp++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_imm !== 32'h0) begin n_err++; $display("FAIL ar_clear got v=%b pc=%h imm=%h exp 0", id_valid, id_pc, id_imm); end
      n_cmp++; if (dbg !== '0) begin n_err++; $display("FAIL ar_dbg got %h exp 0", dbg); end
      model_reset();
      #2 rst = 1;
      if_valid = 1; if_pc = 32'h600; if_inst = 32'h21080000; ex_mem_read = 1; ex_rt = 8;
      #1;
      n_cmp++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL ar_ready_hazard got %b exp 0", id_ready); end
      ex_mem_read = 0; #1;
      n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready_free got %b exp 1", id_ready); end
      tick();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h600) begin n_err++; $display("FAIL ar_accept got v=%b pc=%h exp 1/600", id_valid, id_pc); end
   endtask

   initial begin
      test_reset();
      test_write_dbg();
      test_reg0();
      test_imm();
      test_load_use();
      test_backpressure();
      test_bypass();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
